instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Writer side of the 9-bit ISA: packs symbolic ops (type, opcode, operand field) into 9-bit instruction
//  words and streams them into instruction memory at consecutive addresses. It is the inverse of the
//  control decoder and fills program memory from the bench or a boot source before the core runs.
//  Illegal encodings are rejected and counted, never written.
// PARAMETERS
//  ADDR_W  8    instruction-memory address width; capacity DEPTH = 2**ADDR_W words
//  ERR_W   4    width of the saturating illegal-op counter
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        synchronous, active-high reset
//  start       in   1        begin a load session; sampled only in IDLE or DONE
//  in_valid    in   1        op word offered
//  in_ready    out  1        loader accepts the op this cycle
//  in_type     in   1        0 = R-type, 1 = I-type (becomes instr[8])
//  in_op       in   4        R: rOp[3:0]; I: iOp in [2:0], bit 3 must be 0
//  in_field    in   5        R: reg index in [3:0], bit 4 must be 0; I: 5-bit immediate
//  in_last     in   1        marks the final op of the program
//  imem_we     out  1        instruction-memory write strobe
//  imem_addr   out  ADDR_W   write address
//  imem_wdata  out  9        encoded instruction
//  illegal     out  1        one-cycle pulse: accepted op was dropped as illegal
//  err_cnt     out  ERR_W    count of dropped ops, saturates at all-ones
//  word_cnt    out  ADDR_W+1 number of words written this session
//  done        out  1        session finished (held)
//  overflow    out  1        session ended because memory filled before in_last (held)
// BEHAVIOUR
//  Reset: state IDLE; every output 0; internal address pointer 0.
//  Encoding, fixed: R-type {1'b0, field[3:0], op[3:0]}; I-type {1'b1, field[4:0], op[2:0]}.
//  Illegal: I-type with op[3]=1 or iOp=3'b110; R-type with field[4]=1.
//  FSM IDLE -> LOAD on start. LOAD -> DONE after the handshake carrying in_last, or when the word that
//  fills the memory is accepted. DONE -> LOAD on start. start is ignored in LOAD.
//  Entering LOAD clears the address pointer, word_cnt, err_cnt, done and overflow.
//  in_ready = 1 only in LOAD with word_cnt < DEPTH. A handshake occurs when in_valid & in_ready.
//  Latency: a legal op accepted in cycle N drives imem_we=1 with imem_addr = pointer and
//   imem_wdata = encoded word in cycle N+1. The pointer and word_cnt increment at that write, wrapping
//   never, because the capacity check stops further accepts. imem_we is 0 in every other cycle.
//  Illegal op accepted in cycle N: illegal=1 in N+1, no write, no pointer change, err_cnt+1 (saturating).
//  in_last on an illegal op still ends the session: done=1 from N+1, and nothing is written.
//  Fill: the handshake that brings the committed count to DEPTH sets done=1 in N+1. overflow=1 unless
//   that op carried in_last.
//  Back-to-back: one op per cycle is sustained; in_ready does not drop between legal ops.
//  imem_addr and imem_wdata hold their last values when imem_we=0.
//  A reset asserted mid-session wins over everything: any pending write from the previous cycle is
//   discarded, and the next cycle is IDLE with all outputs 0.
// STRUCTURE
//  Shared package isa_pkg: typedef enum {R_TYPE, I_TYPE}; rOp/iOp enums (ADD..LA, ADDI..LUTA, 3'b110
//  reserved); localparams for field positions and widths; the pure function encode_instr() returning
//  {legal, word[8:0]}. The control decoder uses the same opcode enums.
//  One sub-module, instr_field_packer: a combinational wrapper around encode_instr(). The FSM,
//  counters and output registers live in the top module.
// TESTING
//  1 reset, start, then legal ops ADD r3 (0,4'h0,5'h03), ADDI #5 (1,4'h0,5'h05) with in_last:
//    writes 9'h030 @0 and 9'h128 @1 on consecutive cycles; done=1, word_cnt=2, err_cnt=0.
//  2 Illegal I-op (1,4'h6,any) between two legal ops: illegal pulses once, err_cnt=1, and the legal
//    words land at addresses 0 and 1 with no gap.
//  3 ADDR_W=2, stream 5 ops with no in_last: 4 writes @0..3, in_ready drops after the 4th accept,
//    done=1, overflow=1.
//  4 Illegal op carrying in_last: no write, illegal=1, done=1, overflow=0.
//  5 reset during LOAD in the same cycle as a pending write: no imem_we; next cycle IDLE, all outputs 0.
//  6 start pulsed in LOAD is ignored; start in DONE clears the counters and the address restarts at 0.
//  7 More than 2**ERR_W-1 illegal ops: err_cnt holds at 4'hF.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared definitions for the 9-bit ISA: instruction types, opcode enums, field
// geometry and the canonical encoder used by both the loader and the decoder.
package isa_pkg;

  typedef enum logic {
    R_TYPE = 1'b0,
    I_TYPE = 1'b1
  } instr_type_e;

  typedef enum logic [3:0] {
    R_ADD = 4'h0, R_SUB = 4'h1, R_AND = 4'h2, R_OR  = 4'h3,
    R_XOR = 4'h4, R_NOT = 4'h5, R_SLL = 4'h6, R_SRL = 4'h7,
    R_SRA = 4'h8, R_MOV = 4'h9, R_CMP = 4'hA, R_LW  = 4'hB,
    R_SW  = 4'hC, R_JR  = 4'hD, R_NOP = 4'hE, R_LA  = 4'hF
  } rop_e;

  typedef enum logic [2:0] {
    I_ADDI = 3'b000, I_ANDI = 3'b001, I_ORI  = 3'b010, I_LI   = 3'b011,
    I_BEQ  = 3'b100, I_BNE  = 3'b101, I_RSV  = 3'b110, I_LUTA = 3'b111
  } iop_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } loader_state_e;

  localparam int INSTR_W    = 9;
  localparam int OP_IN_W    = 4;
  localparam int FIELD_IN_W = 5;
  localparam int R_OP_W     = 4;
  localparam int R_FIELD_W  = 4;
  localparam int I_OP_W     = 3;
  localparam int I_FIELD_W  = 5;

  typedef struct packed {
    logic               legal;
    logic [INSTR_W-1:0] word;
  } enc_t;

  function automatic enc_t encode_instr(
    input logic                  typ,
    input logic [OP_IN_W-1:0]    op,
    input logic [FIELD_IN_W-1:0] field
  );
    enc_t r;
    if (typ == I_TYPE) begin
      r.word  = {1'b1, field[I_FIELD_W-1:0], op[I_OP_W-1:0]};
      r.legal = !op[OP_IN_W-1] && (op[I_OP_W-1:0] != I_RSV);
    end else begin
      r.word  = {1'b0, field[R_FIELD_W-1:0], op[R_OP_W-1:0]};
      r.legal = !field[FIELD_IN_W-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: turns one symbolic op into a 9-bit word plus a legality flag.
module instr_field_packer
  import isa_pkg::*;
(
  input  logic                  in_type,
  input  logic [OP_IN_W-1:0]    in_op,
  input  logic [FIELD_IN_W-1:0] in_field,
  output logic                  legal,
  output logic [INSTR_W-1:0]    word
);

  enc_t enc;

  assign enc   = encode_instr(in_type, in_op, in_field);
  assign legal = enc.legal;
  assign word  = enc.word;

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams encoded instructions into instruction memory at consecutive addresses,
// dropping and counting illegal encodings; a session ends on in_last or when memory fills.
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_type,
  input  logic [OP_IN_W-1:0]    in_op,
  input  logic [FIELD_IN_W-1:0] in_field,
  input  logic                  in_last,
  output logic                  imem_we,
  output logic [ADDR_W-1:0]     imem_addr,
  output logic [INSTR_W-1:0]    imem_wdata,
  output logic                  illegal,
  output logic [ERR_W-1:0]      err_cnt,
  output logic [ADDR_W:0]       word_cnt,
  output logic                  done,
  output logic                  overflow
);

  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'((2**ADDR_W) - 1);

  loader_state_e        state_reg, state_next;
  logic                 imem_we_reg;
  logic [ADDR_W-1:0]    imem_addr_reg;
  logic [INSTR_W-1:0]   imem_wdata_reg;
  logic                 illegal_reg;
  logic [ERR_W-1:0]     err_cnt_reg;
  logic [ADDR_W:0]      word_cnt_reg;
  logic                 done_reg;
  logic                 overflow_reg;

  logic                 op_legal;
  logic [INSTR_W-1:0]   op_word;
  logic                 ready;
  logic                 handshake;
  logic                 session_start;
  logic                 fill;

  instr_field_packer u_packer (
    .in_type  (in_type),
    .in_op    (in_op),
    .in_field (in_field),
    .legal    (op_legal),
    .word     (op_word)
  );

  // Only a legal write can occupy the final slot; an illegal op never fills memory.
  assign fill = op_legal && (word_cnt_reg == LAST_SLOT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start) state_next = S_LOAD;
      S_LOAD: if (handshake && (in_last || fill)) state_next = S_DONE;
      S_DONE: if (start) state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready         = (state_reg == S_LOAD) && !word_cnt_reg[ADDR_W];
    handshake     = in_valid && ready;
    session_start = (state_reg != S_LOAD) && start;
  end

  // Everything below is captured on the handshake edge, so the write appears one cycle later
  // while word_cnt already reflects it; that keeps the capacity check exact at full rate.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
      illegal_reg    <= 1'b0;
      err_cnt_reg    <= '0;
      word_cnt_reg   <= '0;
      done_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      imem_we_reg <= 1'b0;
      illegal_reg <= 1'b0;
      if (session_start) begin
        err_cnt_reg  <= '0;
        word_cnt_reg <= '0;
        done_reg     <= 1'b0;
        overflow_reg <= 1'b0;
      end else if (handshake) begin
        if (op_legal) begin
          imem_we_reg    <= 1'b1;
          imem_addr_reg  <= word_cnt_reg[ADDR_W-1:0];
          imem_wdata_reg <= op_word;
          word_cnt_reg   <= word_cnt_reg + 1'b1;
        end else begin
          illegal_reg <= 1'b1;
          if (err_cnt_reg != '1) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
          end
        end
        if (in_last || fill) begin
          done_reg     <= 1'b1;
          overflow_reg <= !in_last;
        end
      end
    end
  end

  assign in_ready   = ready;
  assign imem_we    = imem_we_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = imem_wdata_reg;
  assign illegal    = illegal_reg;
  assign err_cnt    = err_cnt_reg;
  assign word_cnt   = word_cnt_reg;
  assign done       = done_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios then random traffic, every cycle
// compared against a session-level reference model built from the encoding rules.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 2;
  localparam int ERR_W  = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_type = 1'b0;
  logic [3:0]        in_op = '0;
  logic [4:0]        in_field = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [8:0]        imem_wdata;
  logic              illegal;
  logic [ERR_W-1:0]  err_cnt;
  logic [ADDR_W:0]   word_cnt;
  logic              done;
  logic              overflow;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_type    (in_type),
    .in_op      (in_op),
    .in_field   (in_field),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .illegal    (illegal),
    .err_cnt    (err_cnt),
    .word_cnt   (word_cnt),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: session flags, counts and the expected registered outputs.
  bit m_load = 0, m_done = 0, m_ovf = 0, e_we = 0, e_ill = 0;
  int m_cnt = 0, m_err = 0, e_addr = 0, e_wdata = 0;
  int wr_addr_log[$];
  int wr_data_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit st, input bit v, input bit t,
                       input int op, input int fld, input bit last);
    bit exp_ready, hs, legal;
    int word;
    reset = rst; start = st; in_valid = v; in_type = t;
    in_op = op[3:0]; in_field = fld[4:0]; in_last = last;
    exp_ready = m_load && (m_cnt < DEPTH);
    #1;
    if (!rst) check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    @(posedge clk);
    hs    = v && exp_ready;
    legal = t ? ((op < 8) && (op != 6)) : (fld < 16);
    word  = t ? (256 + fld * 8 + (op % 8)) : ((fld % 16) * 16 + op);
    e_we  = 0;
    e_ill = 0;
    if (rst) begin
      m_load = 0; m_done = 0; m_ovf = 0; m_cnt = 0; m_err = 0; e_addr = 0; e_wdata = 0;
    end else if (!m_load) begin
      if (st) begin
        m_load = 1; m_cnt = 0; m_err = 0; m_done = 0; m_ovf = 0;
      end
    end else if (hs) begin
      $display("txn type=%0d op=%0h field=%0h last=%0d -> %s addr=%0d word=%03h",
               t, op, fld, last, legal ? "write" : "drop", m_cnt, word);
      if (legal) begin
        e_we = 1; e_addr = m_cnt; e_wdata = word; m_cnt++;
      end else begin
        e_ill = 1;
        if (m_err < 2 ** ERR_W - 1) m_err++;
      end
      if (last || m_cnt == DEPTH) begin
        m_load = 0; m_done = 1; m_ovf = !last;
      end
    end
    #1;
    check_eq("imem_we",    {31'd0, imem_we}, {31'd0, e_we});
    check_eq("imem_addr",  32'(imem_addr), e_addr);
    check_eq("imem_wdata", 32'(imem_wdata), e_wdata);
    check_eq("illegal",    {31'd0, illegal}, {31'd0, e_ill});
    check_eq("err_cnt",    32'(err_cnt), m_err);
    check_eq("word_cnt",   32'(word_cnt), m_cnt);
    check_eq("done",       {31'd0, done}, {31'd0, m_done});
    check_eq("overflow",   {31'd0, overflow}, {31'd0, m_ovf});
    if (imem_we === 1'b1) begin
      wr_addr_log.push_back(int'(imem_addr));
      wr_data_log.push_back(int'(imem_wdata));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic begin_session();
    cycle(0, 1, 0, 0, 0, 0, 0);
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(1);

    // ADD r3 then ADDI #5 with in_last
    begin_session();
    cycle(0, 0, 1, 0, 0, 3, 0);
    cycle(0, 0, 1, 1, 0, 5, 1);
    idle(1);
    check_eq("t1_nwrites", wr_data_log.size(), 2);
    if (wr_data_log.size() == 2) begin
      check_eq("t1_word0", wr_data_log[0], 32'h030);
      check_eq("t1_addr0", wr_addr_log[0], 0);
      check_eq("t1_word1", wr_data_log[1], 32'h128);
      check_eq("t1_addr1", wr_addr_log[1], 1);
    end
    check_eq("t1_done", {31'd0, done}, 1);
    check_eq("t1_word_cnt", 32'(word_cnt), 2);

    // reserved I-op sandwiched between legal ops
    begin_session();
    cycle(0, 0, 1, 0, 2, 1, 0);
    cycle(0, 0, 1, 1, 6, 7, 0);
    cycle(0, 0, 1, 1, 2, 9, 1);
    idle(1);
    check_eq("t2_err_cnt", 32'(err_cnt), 1);
    if (wr_addr_log.size() == 2) begin
      check_eq("t2_addr0", wr_addr_log[0], 0);
      check_eq("t2_addr1", wr_addr_log[1], 1);
    end else check_eq("t2_nwrites", wr_addr_log.size(), 2);

    // five ops without in_last into a 4-word memory
    begin_session();
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, i, i, 0);
    idle(1);
    check_eq("t3_nwrites", wr_data_log.size(), DEPTH);
    check_eq("t3_overflow", {31'd0, overflow}, 1);

    // illegal op carrying in_last
    begin_session();
    cycle(0, 0, 1, 1, 9, 0, 1);
    idle(1);
    check_eq("t4_done", {31'd0, done}, 1);
    check_eq("t4_overflow", {31'd0, overflow}, 0);

    // reset in the same cycle as an accepted legal op
    begin_session();
    cycle(0, 0, 1, 0, 1, 1, 0);
    cycle(1, 0, 1, 0, 2, 3, 0);
    idle(2);

    // start ignored in LOAD, then restart from DONE
    begin_session();
    cycle(0, 0, 1, 0, 4, 2, 0);
    cycle(0, 1, 1, 0, 5, 2, 0);
    cycle(0, 0, 1, 1, 3, 4, 1);
    begin_session();
    cycle(0, 0, 1, 0, 7, 7, 1);
    idle(1);
    if (wr_addr_log.size() == 1) check_eq("t6_restart_addr", wr_addr_log[0], 0);
    else check_eq("t6_nwrites", wr_addr_log.size(), 1);

    // saturation of the illegal-op counter
    begin_session();
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 0, i % 16, 16 + (i % 16), 0);
    idle(1);
    check_eq("t7_err_sat", 32'(err_cnt), 32'hF);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 200) == 0, ($urandom % 10) == 0, ($urandom % 4) != 0,
            1'($urandom % 2), int'($urandom % 16), int'($urandom % 32), ($urandom % 8) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
